// File: rtl/audio_fs_detect.sv
// rtl/audio_fs_detect.sv - audio sample-rate detector measuring LRCK period in clk cycles
// Classifies each LRCK period, debounces the class, and reports a locked rate code.
module audio_fs_detect #(
  parameter logic [15:0] FREQ_32K   = 16'h1,
  parameter logic [15:0] FREQ_441K  = 16'h2,
  parameter logic [15:0] FREQ_48K   = 16'h3,
  parameter logic [15:0] FREQ_96K   = 16'h4,
  parameter int          STABLE_CNT = 4,
  parameter int          TIMEOUT    = 2047
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lrck,
  output logic [15:0] audio_freq_mode,
  output logic        locked,
  output logic        mode_change
);

  localparam int          MW        = $clog2(STABLE_CNT + 1);
  localparam logic [10:0] TIMEOUT_C = 11'(TIMEOUT);
  localparam logic [MW-1:0] STABLE_C = MW'(STABLE_CNT);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  logic          sync1_q, sync2_q, sync3_q;
  logic [10:0]   cnt_q, cnt_d;
  logic          ref_q, ref_d;
  logic [15:0]   cand_q, cand_d;
  logic [MW-1:0] match_q, match_d;
  logic [15:0]   cls;
  logic          rise, timeout, classify, reach;

  state_t        state_q;
  logic [15:0]   mode_q;
  logic          locked_q;
  logic          pulse_q;

  assign rise     = sync2_q & ~sync3_q;
  assign classify = rise & ref_q;

  // Saturating counter; the timeout fires once, on the cycle it reaches TIMEOUT.
  always_comb begin
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (rise) begin
      cnt_d = 11'd1;
    end else if (cnt_q != TIMEOUT_C) begin
      cnt_d = cnt_q + 11'd1;
      if (cnt_q == TIMEOUT_C - 11'd1) timeout = 1'b1;
    end
  end

  always_comb begin
    cls = 16'h0;
    if (cnt_q >= 11'd240 && cnt_q <= 11'd272)      cls = FREQ_96K;
    else if (cnt_q >= 11'd496 && cnt_q <= 11'd528) cls = FREQ_48K;
    else if (cnt_q >= 11'd541 && cnt_q <= 11'd573) cls = FREQ_441K;
    else if (cnt_q >= 11'd744 && cnt_q <= 11'd792) cls = FREQ_32K;
  end

  always_comb begin
    ref_d   = ref_q;
    cand_d  = cand_q;
    match_d = match_q;
    if (timeout) begin
      ref_d   = 1'b0;
      cand_d  = 16'h0;
      match_d = '0;
    end else if (rise) begin
      ref_d = 1'b1;
      if (classify) begin
        if (cls == cand_q) begin
          if (match_q != STABLE_C) match_d = match_q + 1'b1;
        end else begin
          cand_d  = cls;
          match_d = MW'(1);
        end
      end
    end
  end

  assign reach = classify && (match_d == STABLE_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      cnt_q   <= 11'd0;
      ref_q   <= 1'b0;
      cand_q  <= 16'h0;
      match_q <= '0;
    end else begin
      sync1_q <= lrck;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      cand_q  <= cand_d;
      match_q <= match_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEARCH;
      mode_q   <= 16'h0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        SEARCH: begin
          if (reach && cand_d != 16'h0) begin
            state_q  <= LOCKED;
            mode_q   <= cand_d;
            locked_q <= 1'b1;
            pulse_q  <= 1'b1;
          end
        end
        LOCKED: begin
          if (timeout || (reach && cand_d == 16'h0)) begin
            state_q  <= SEARCH;
            mode_q   <= 16'h0;
            locked_q <= 1'b0;
            pulse_q  <= 1'b1;
          end else if (reach && cand_d != mode_q) begin
            mode_q  <= cand_d;
            pulse_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= SEARCH;
          mode_q   <= 16'h0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign audio_freq_mode = mode_q;
  assign locked          = locked_q;
  assign mode_change     = pulse_q;

endmodule

// File: tb/tb_audio_fs_detect.sv
// tb/tb_audio_fs_detect.sv - directed-vector bench for audio_fs_detect
module tb_audio_fs_detect;

  logic        clk;
  logic        rst_n;
  logic        lrck;
  logic [15:0] audio_freq_mode;
  logic        locked;
  logic        mode_change;

  int vec_cnt;
  int err_cnt;
  int pulse_cnt;

  audio_fs_detect dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .lrck            (lrck),
    .audio_freq_mode (audio_freq_mode),
    .locked          (locked),
    .mode_change     (mode_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (mode_change === 1'b1) pulse_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Each iteration begins with an LRCK rising edge and lasts n clk cycles.
  task automatic periods(input int n, input int count);
    repeat (count) begin
      lrck = 1'b1;
      tick(n / 2);
      lrck = 1'b0;
      tick(n - n / 2);
    end
  endtask

  task automatic half_start();
    lrck = 1'b1;
    tick(4);
  endtask

  task automatic half_rest(input int n);
    tick(n / 2 - 4);
    lrck = 1'b0;
    tick(n - n / 2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    lrck  = 1'b0;
    tick(5);
    vec_cnt++;
    if (audio_freq_mode !== 16'h0) begin
      err_cnt++; $display("FAIL reset_mode: got %0h expected 0", audio_freq_mode);
    end
    vec_cnt++;
    if (locked !== 1'b0) begin
      err_cnt++; $display("FAIL reset_locked: got %b expected 0", locked);
    end
    vec_cnt++;
    if (mode_change !== 1'b0) begin
      err_cnt++; $display("FAIL reset_pulse: got %b expected 0", mode_change);
    end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_lock_48k();
    pulse_cnt = 0;
    periods(512, 4);
    vec_cnt++;
    if (audio_freq_mode !== 16'h0) begin
      err_cnt++; $display("FAIL lock48_early: got %0h expected 0", audio_freq_mode);
    end
    half_start();
    vec_cnt++;
    if (audio_freq_mode !== 16'h3) begin
      err_cnt++; $display("FAIL lock48_mode: got %0h expected 3", audio_freq_mode);
    end
    vec_cnt++;
    if (locked !== 1'b1) begin
      err_cnt++; $display("FAIL lock48_locked: got %b expected 1", locked);
    end
    half_rest(512);
    periods(512, 2);
    vec_cnt++;
    if (pulse_cnt !== 1) begin
      err_cnt++; $display("FAIL lock48_pulses: got %0d expected 1", pulse_cnt);
    end
  endtask

  task automatic test_switch_96k();
    pulse_cnt = 0;
    periods(256, 4);
    vec_cnt++;
    if (audio_freq_mode !== 16'h3) begin
      err_cnt++; $display("FAIL sw96_hold: got %0h expected 3", audio_freq_mode);
    end
    half_start();
    vec_cnt++;
    if (audio_freq_mode !== 16'h4) begin
      err_cnt++; $display("FAIL sw96_mode: got %0h expected 4", audio_freq_mode);
    end
    vec_cnt++;
    if (pulse_cnt !== 1 || locked !== 1'b1) begin
      err_cnt++; $display("FAIL sw96_pulse: got pulses %0d locked %b expected 1 1", pulse_cnt, locked);
    end
    half_rest(256);
  endtask

  task automatic test_441k_glitch();
    pulse_cnt = 0;
    periods(557, 1);
    periods(558, 1);
    periods(557, 1);
    periods(558, 1);
    vec_cnt++;
    if (audio_freq_mode !== 16'h4) begin
      err_cnt++; $display("FAIL f441_hold: got %0h expected 4", audio_freq_mode);
    end
    half_start();
    vec_cnt++;
    if (audio_freq_mode !== 16'h2 || locked !== 1'b1) begin
      err_cnt++; $display("FAIL f441_mode: got %0h/%b expected 2/1", audio_freq_mode, locked);
    end
    half_rest(557);
    pulse_cnt = 0;
    periods(400, 1);
    periods(558, 1);
    periods(557, 1);
    half_start();
    vec_cnt++;
    if (audio_freq_mode !== 16'h2 || locked !== 1'b1 || pulse_cnt !== 0) begin
      err_cnt++; $display("FAIL glitch_reject: got %0h/%b pulses %0d expected 2/1 0",
                          audio_freq_mode, locked, pulse_cnt);
    end
    half_rest(558);
  endtask

  task automatic test_timeout();
    pulse_cnt = 0;
    lrck = 1'b1;
    tick(4);
    lrck = 1'b0;
    tick(2044);
    vec_cnt++;
    if (locked !== 1'b1 || pulse_cnt !== 0) begin
      err_cnt++; $display("FAIL tmo_early: got locked %b pulses %0d expected 1 0", locked, pulse_cnt);
    end
    tick(1);
    vec_cnt++;
    if (locked !== 1'b0 || audio_freq_mode !== 16'h0) begin
      err_cnt++; $display("FAIL tmo_drop: got %b/%0h expected 0/0", locked, audio_freq_mode);
    end
    tick(100);
    vec_cnt++;
    if (pulse_cnt !== 1) begin
      err_cnt++; $display("FAIL tmo_pulse: got %0d expected 1", pulse_cnt);
    end
    periods(768, 4);
    vec_cnt++;
    if (audio_freq_mode !== 16'h0) begin
      err_cnt++; $display("FAIL relock32_early: got %0h expected 0", audio_freq_mode);
    end
    half_start();
    vec_cnt++;
    if (audio_freq_mode !== 16'h1 || locked !== 1'b1 || pulse_cnt !== 2) begin
      err_cnt++; $display("FAIL relock32: got %0h/%b pulses %0d expected 1/1 2",
                          audio_freq_mode, locked, pulse_cnt);
    end
    half_rest(768);
  endtask

  task automatic test_invalid_600();
    pulse_cnt = 0;
    periods(600, 4);
    vec_cnt++;
    if (audio_freq_mode !== 16'h1 || locked !== 1'b1) begin
      err_cnt++; $display("FAIL inv600_hold: got %0h/%b expected 1/1", audio_freq_mode, locked);
    end
    half_start();
    vec_cnt++;
    if (audio_freq_mode !== 16'h0 || locked !== 1'b0 || pulse_cnt !== 1) begin
      err_cnt++; $display("FAIL inv600_drop: got %0h/%b pulses %0d expected 0/0 1",
                          audio_freq_mode, locked, pulse_cnt);
    end
    half_rest(600);
  endtask

  task automatic test_bounds();
    periods(240, 1);
    periods(272, 1);
    periods(240, 1);
    periods(272, 1);
    half_start();
    vec_cnt++;
    if (audio_freq_mode !== 16'h4 || locked !== 1'b1) begin
      err_cnt++; $display("FAIL bound_incl: got %0h/%b expected 4/1", audio_freq_mode, locked);
    end
    half_rest(240);
    periods(273, 4);
    half_start();
    vec_cnt++;
    if (audio_freq_mode !== 16'h0 || locked !== 1'b0) begin
      err_cnt++; $display("FAIL bound_excl: got %0h/%b expected 0/0", audio_freq_mode, locked);
    end
    half_rest(273);
  endtask

  task automatic test_reset_midlock();
    periods(512, 5);
    vec_cnt++;
    if (audio_freq_mode !== 16'h3) begin
      err_cnt++; $display("FAIL midlock_pre: got %0h expected 3", audio_freq_mode);
    end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (audio_freq_mode !== 16'h0 || locked !== 1'b0) begin
      err_cnt++; $display("FAIL async_reset: got %0h/%b expected 0/0", audio_freq_mode, locked);
    end
    tick(3);
    rst_n = 1'b1;
    tick(2);
    periods(512, 4);
    vec_cnt++;
    if (locked !== 1'b0) begin
      err_cnt++; $display("FAIL relock_history: got %b expected 0", locked);
    end
    half_start();
    vec_cnt++;
    if (audio_freq_mode !== 16'h3 || locked !== 1'b1) begin
      err_cnt++; $display("FAIL relock48: got %0h/%b expected 3/1", audio_freq_mode, locked);
    end
    half_rest(512);
  endtask

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    pulse_cnt = 0;
    rst_n     = 1'b0;
    lrck      = 1'b0;
    @(posedge clk);
    #2;
    test_reset();
    test_lock_48k();
    test_switch_96k();
    test_441k_glitch();
    test_timeout();
    test_invalid_600();
    test_bounds();
    test_reset_midlock();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/audio_fs_detect.md
AUDIO_FS_DETECT -- requirements
Module: audio_fs_detect

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- FREQ_32K, 16'h1, code for 32 kHz
- FREQ_441K, 16'h2, code for 44.1 kHz
- FREQ_48K, 16'h3, code for 48 kHz
- FREQ_96K, 16'h4, code for 96 kHz
- STABLE_CNT, 4, consecutive matching periods needed to change mode
- TIMEOUT, 2047, clk cycles without an LRCK rising edge before lock loss
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, input, 1, system clock (24.576 MHz nominal)
- rst_n, input, 1, reset; asynchronous, active-low
- lrck, input, 1, audio word clock, asynchronous to clk
- audio_freq_mode, output, 16, detected rate code (0 = none, else FREQ_*)
- locked, output, 1, high while audio_freq_mode holds a valid code
- mode_change, output, 1, one-cycle pulse on any audio_freq_mode change

Function
REQ-003 lrck SHALL pass through a 2-flop synchronizer; a rising edge SHALL be detected from the synchronized signal and its registered copy.
REQ-004 An 11-bit period counter SHALL count clk cycles between consecutive detected rising edges; measured period = cycles from one edge-detect cycle to the next (edges 512 cycles apart -> 512).
REQ-005 The counter SHALL saturate at TIMEOUT; reaching TIMEOUT is a timeout event.
REQ-006 The first edge after reset or after a timeout SHALL only restart counting and SHALL NOT be classified.
REQ-007 Classification SHALL be inclusive: 240..272 -> FREQ_96K; 496..528 -> FREQ_48K; 541..573 -> FREQ_441K; 744..792 -> FREQ_32K; any other value -> invalid (0).
REQ-008 Candidate tracking per classified period: class equal to candidate -> match count +1, saturating at STABLE_CNT; otherwise candidate = class, match count = 1.
REQ-009 FSM SHALL have two states, SEARCH and LOCKED; reset enters SEARCH.
REQ-010 SEARCH -> LOCKED when a valid candidate's match count reaches STABLE_CNT; audio_freq_mode = candidate, locked = 1, mode_change pulses.
REQ-011 In LOCKED, a valid candidate reaching STABLE_CNT with a code different from audio_freq_mode SHALL update audio_freq_mode and pulse mode_change; the state stays LOCKED.
REQ-012 In LOCKED, an invalid candidate reaching STABLE_CNT, or a timeout, SHALL go to SEARCH with audio_freq_mode = 0, locked = 0, and one mode_change pulse.
REQ-013 A timeout in SEARCH SHALL clear the candidate and SHALL NOT pulse mode_change.
REQ-014 Fewer than STABLE_CNT consecutive deviating periods SHALL leave all outputs unchanged (glitch rejection).
REQ-015 Outputs SHALL update in the clk cycle following the edge-detect cycle that completes the qualifying period; pin-to-output latency is at most 4 clk after the lrck rising edge.
REQ-016 mode_change SHALL be exactly one clk wide; it SHALL never assert when audio_freq_mode is unchanged.
REQ-017 An edge coincident with counter saturation SHALL be treated as an edge; no timeout is raised.

Reset
REQ-018 While rst_n = 0: audio_freq_mode = 0, locked = 0, mode_change = 0, counter = 0, candidate = 0, match count = 0, synchronizer flops = 0, state = SEARCH; all apply immediately, without waiting for clk.
REQ-019 A reset asserted mid-lock SHALL discard all history; re-lock SHALL require a first edge plus STABLE_CNT full periods.

Verification
REQ-020 Reset, then a 512-cycle lrck -> after the 5th rising edge: audio_freq_mode = 3, locked = 1, one mode_change pulse.
REQ-021 Locked at 48 kHz, switch to 256-cycle periods -> mode stays 3 for 3 periods, then 4 on the 4th, one pulse.
REQ-022 Periods alternating 557/558 -> mode = 2 and locked; a single 400-cycle period inserted -> no output change.
REQ-023 Locked, lrck held low -> 2047 cycles after the last edge: mode = 0, locked = 0, one pulse; lrck restart at 768 -> mode = 1 after the first edge plus 4 periods.
REQ-024 Locked, four consecutive 600-cycle periods -> mode = 0, locked = 0 after the 4th; rst_n pulsed low mid-lock -> outputs 0 asynchronously.
